// File: rtl/exc_addr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_addr_ctrl
// Description : Sequences address-error exceptions and ERET. Owns KSU/EXL,
//               latches EPC/BadVAddr/ExcCode, then flushes and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_addr_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        instruction_addr_illegal,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_addr,
    input  logic        mem_is_store,
    input  logic        data_addr_illegal,
    input  logic        eret,
    input  logic        ksu_we,
    input  logic [1:0]  ksu_wdata,
    input  logic        redirect_ready,
    output logic [1:0]  status_ksu,
    output logic        status_exl,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic [31:0] badvaddr,
    output logic [4:0]  exccode
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_load  = 4'(FLUSH_CYCLES - 1);
    localparam logic [4:0] c_exc_adel  = 5'd4;
    localparam logic [4:0] c_exc_ades  = 5'd5;

    state_t      r_state, w_state;
    logic [3:0]  r_cnt, w_cnt;
    logic        r_flush, w_flush;
    logic        r_rv, w_rv;
    logic [31:0] r_rpc, w_rpc;
    logic [31:0] r_epc, w_epc;
    logic [31:0] r_bad, w_bad;
    logic [4:0]  r_exccode, w_exccode;
    logic [1:0]  r_ksu, w_ksu;
    logic        r_exl, w_exl;
    logic [1:0]  r_saved_ksu, w_saved_ksu;

    logic        w_data_err;
    logic        w_fetch_err;
    logic [31:0] w_exc_pc;

    assign w_data_err  = mem_valid & data_addr_illegal;
    assign w_fetch_err = if_valid & instruction_addr_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_flush     <= 1'b0;
            r_rv        <= 1'b0;
            r_rpc       <= 32'd0;
            r_epc       <= 32'd0;
            r_bad       <= 32'd0;
            r_exccode   <= 5'd0;
            r_ksu       <= 2'b00;
            r_exl       <= 1'b0;
            r_saved_ksu <= 2'b00;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_flush     <= w_flush;
            r_rv        <= w_rv;
            r_rpc       <= w_rpc;
            r_epc       <= w_epc;
            r_bad       <= w_bad;
            r_exccode   <= w_exccode;
            r_ksu       <= w_ksu;
            r_exl       <= w_exl;
            r_saved_ksu <= w_saved_ksu;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_flush     = r_flush;
        w_rv        = r_rv;
        w_rpc       = r_rpc;
        w_epc       = r_epc;
        w_bad       = r_bad;
        w_exccode   = r_exccode;
        w_ksu       = r_ksu;
        w_exl       = r_exl;
        w_saved_ksu = r_saved_ksu;
        w_exc_pc    = w_data_err ? mem_pc : if_pc;

        case (r_state)
            ST_IDLE: begin
                if (w_data_err || w_fetch_err) begin
                    // Data error outranks fetch error; a pending ERET is dropped.
                    w_bad     = w_data_err ? mem_addr : if_pc;
                    w_exccode = (w_data_err && mem_is_store) ? c_exc_ades : c_exc_adel;
                    if (!r_exl) begin
                        w_epc       = w_exc_pc;
                        w_saved_ksu = r_ksu;
                    end
                    w_exl   = 1'b1;
                    w_ksu   = 2'b00;
                    w_rpc   = EXC_VECTOR;
                    w_state = ST_FLUSH;
                    w_flush = 1'b1;
                    w_cnt   = c_cnt_load;
                end else if (eret && r_exl) begin
                    w_ksu   = r_saved_ksu;
                    w_exl   = 1'b0;
                    w_rpc   = r_epc;
                    w_state = ST_FLUSH;
                    w_flush = 1'b1;
                    w_cnt   = c_cnt_load;
                end else if (ksu_we) begin
                    w_ksu = (ksu_wdata == 2'b11) ? 2'b10 : ksu_wdata;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == 4'd0) begin
                    w_state = ST_REDIRECT;
                    w_flush = 1'b0;
                    w_rv    = 1'b1;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            ST_REDIRECT: begin
                if (r_rv && redirect_ready) begin
                    w_state = ST_IDLE;
                    w_rv    = 1'b0;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_flush = 1'b0;
                w_rv    = 1'b0;
            end
        endcase
    end

    assign status_ksu     = r_ksu;
    assign status_exl     = r_exl;
    assign flush          = r_flush;
    assign redirect_valid = r_rv;
    assign redirect_pc    = r_rpc;
    assign epc            = r_epc;
    assign badvaddr       = r_bad;
    assign exccode        = r_exccode;

endmodule
`default_nettype wire

// File: tb/tb_exc_addr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_addr_ctrl
// Description : Directed self-checking bench for exc_addr_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_addr_ctrl;

    localparam logic [31:0] c_vec = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        instruction_addr_illegal;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_addr;
    logic        mem_is_store;
    logic        data_addr_illegal;
    logic        eret;
    logic        ksu_we;
    logic [1:0]  ksu_wdata;
    logic        redirect_ready;
    logic [1:0]  status_ksu;
    logic        status_exl;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [4:0]  exccode;

    int tests  = 0;
    int failed = 0;

    exc_addr_ctrl #(.EXC_VECTOR(c_vec), .FLUSH_CYCLES(2)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .if_valid                 (if_valid),
        .if_pc                    (if_pc),
        .instruction_addr_illegal (instruction_addr_illegal),
        .mem_valid                (mem_valid),
        .mem_pc                   (mem_pc),
        .mem_addr                 (mem_addr),
        .mem_is_store             (mem_is_store),
        .data_addr_illegal        (data_addr_illegal),
        .eret                     (eret),
        .ksu_we                   (ksu_we),
        .ksu_wdata                (ksu_wdata),
        .redirect_ready           (redirect_ready),
        .status_ksu               (status_ksu),
        .status_exl               (status_exl),
        .flush                    (flush),
        .redirect_valid           (redirect_valid),
        .redirect_pc              (redirect_pc),
        .epc                      (epc),
        .badvaddr                 (badvaddr),
        .exccode                  (exccode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_valid = 0; if_pc = 0; instruction_addr_illegal = 0;
        mem_valid = 0; mem_pc = 0; mem_addr = 0; mem_is_store = 0;
        data_addr_illegal = 0; eret = 0; ksu_we = 0; ksu_wdata = 0;
    endtask

    initial begin
        rst = 1'b1;
        redirect_ready = 1'b0;
        clear_inputs();
        step(); step();
        chk("rst_ksu", 32'(status_ksu), 0);
        chk("rst_exl", 32'(status_exl), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_rv", 32'(redirect_valid), 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_epc", epc, 0);
        chk("rst_bad", badvaddr, 0);
        chk("rst_exccode", 32'(exccode), 0);
        rst = 1'b0;
        step();

        // MTC0 of 11 is stored as user mode 10
        ksu_we = 1; ksu_wdata = 2'b11;
        step();
        clear_inputs();
        chk("mtc0_11", 32'(status_ksu), 32'h2);

        // Fetch error from user mode
        if_valid = 1; if_pc = 32'h0040_0002; instruction_addr_illegal = 1;
        step();
        clear_inputs();
        chk("f_epc", epc, 32'h0040_0002);
        chk("f_bad", badvaddr, 32'h0040_0002);
        chk("f_code", 32'(exccode), 4);
        chk("f_ksu", 32'(status_ksu), 0);
        chk("f_exl", 32'(status_exl), 1);
        chk("f_flush1", 32'(flush), 1);
        chk("f_rv_early", 32'(redirect_valid), 0);
        step();
        chk("f_flush2", 32'(flush), 1);
        step();
        chk("f_flush_off", 32'(flush), 0);
        chk("f_rv", 32'(redirect_valid), 1);
        chk("f_rpc", redirect_pc, c_vec);
        redirect_ready = 1;
        step();
        chk("f_rv_done", 32'(redirect_valid), 0);

        // ERET round trip back to user mode
        eret = 1;
        step();
        clear_inputs();
        chk("e_ksu", 32'(status_ksu), 32'h2);
        chk("e_exl", 32'(status_exl), 0);
        chk("e_flush1", 32'(flush), 1);
        step();
        chk("e_flush2", 32'(flush), 1);
        step();
        chk("e_rv", 32'(redirect_valid), 1);
        chk("e_rpc", redirect_pc, 32'h0040_0002);
        step();
        chk("e_rv_done", 32'(redirect_valid), 0);

        // Store error, fetch error and ERET together: data error wins
        redirect_ready = 0;
        mem_valid = 1; mem_pc = 32'h0040_0010; mem_addr = 32'h1000_0001;
        mem_is_store = 1; data_addr_illegal = 1;
        if_valid = 1; if_pc = 32'h0040_0020; instruction_addr_illegal = 1;
        eret = 1;
        step();
        clear_inputs();
        chk("d_epc", epc, 32'h0040_0010);
        chk("d_bad", badvaddr, 32'h1000_0001);
        chk("d_code", 32'(exccode), 5);
        chk("d_exl", 32'(status_exl), 1);
        chk("d_ksu", 32'(status_ksu), 0);
        step();
        step();
        chk("d_rv", 32'(redirect_valid), 1);
        chk("d_rpc", redirect_pc, c_vec);

        // Backpressure: everything pulsed while waiting is ignored
        for (int i = 0; i < 5; i++) begin
            mem_valid = 1; mem_pc = 32'h0000_1111; mem_addr = 32'h0000_2223;
            data_addr_illegal = 1; eret = 1; ksu_we = 1; ksu_wdata = 2'b01;
            step();
            clear_inputs();
            chk("bp_rv", 32'(redirect_valid), 1);
            chk("bp_flush", 32'(flush), 0);
            chk("bp_epc", epc, 32'h0040_0010);
            chk("bp_bad", badvaddr, 32'h1000_0001);
            chk("bp_ksu", 32'(status_ksu), 0);
        end
        redirect_ready = 1;
        step();
        chk("bp_release", 32'(redirect_valid), 0);

        // Nested load error: EPC kept, BadVAddr updated
        mem_valid = 1; mem_pc = 32'h8000_0100; mem_addr = 32'h8000_0101;
        mem_is_store = 0; data_addr_illegal = 1;
        step();
        clear_inputs();
        chk("n_epc", epc, 32'h0040_0010);
        chk("n_bad", badvaddr, 32'h8000_0101);
        chk("n_code", 32'(exccode), 4);
        step(); step();
        chk("n_rpc", redirect_pc, c_vec);
        step();
        eret = 1;
        step();
        clear_inputs();
        chk("n_eret_ksu", 32'(status_ksu), 32'h2);
        chk("n_eret_exl", 32'(status_exl), 0);
        step(); step();
        chk("n_eret_rpc", redirect_pc, 32'h0040_0010);
        step();

        // ERET with EXL clear does nothing
        eret = 1;
        step();
        clear_inputs();
        chk("eret0_flush", 32'(flush), 0);
        chk("eret0_exl", 32'(status_exl), 0);

        // Reset during first flush cycle
        if_valid = 1; if_pc = 32'h0040_0040; instruction_addr_illegal = 1;
        step();
        clear_inputs();
        chk("r_flush_pre", 32'(flush), 1);
        #2 rst = 1'b1;
        #1;
        chk("r_flush", 32'(flush), 0);
        chk("r_epc", epc, 0);
        chk("r_exl", 32'(status_exl), 0);
        chk("r_rpc", redirect_pc, 0);
        chk("r_bad", badvaddr, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r_no_rv", 32'(redirect_valid), 0);
            chk("r_no_flush", 32'(flush), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
